// File: rtl/fma16_arb_if.sv
// Bundle of requester, shared fp16 FMA datapath and response signals for fma16_arb.
// slave is the arbiter's view; master is the view of the surrounding requesters/datapath/consumer.
interface fma16_arb_if;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [31:0] reqX;
    logic [31:0] reqY;
    logic [31:0] reqZ;
    logic [1:0]  reqMul;
    logic [1:0]  reqAdd;
    logic [3:0]  reqRm;

    logic [15:0] fmaX;
    logic [15:0] fmaY;
    logic [15:0] fmaZ;
    logic        fmaMul;
    logic        fmaAdd;
    logic [1:0]  fmaRm;
    logic [15:0] fmaResult;
    logic [3:0]  fmaFlags;

    logic        rspValid;
    logic        rspReady;
    logic        rspId;
    logic [15:0] rspResult;
    logic [3:0]  rspFlags;
    logic        busy;

    modport slave (
        input  reqValid, reqX, reqY, reqZ, reqMul, reqAdd, reqRm,
        input  fmaResult, fmaFlags, rspReady,
        output reqReady, fmaX, fmaY, fmaZ, fmaMul, fmaAdd, fmaRm,
        output rspValid, rspId, rspResult, rspFlags, busy
    );

    modport master (
        output reqValid, reqX, reqY, reqZ, reqMul, reqAdd, reqRm,
        output fmaResult, fmaFlags, rspReady,
        input  reqReady, fmaX, fmaY, fmaZ, fmaMul, fmaAdd, fmaRm,
        input  rspValid, rspId, rspResult, rspFlags, busy
    );
endinterface

// File: rtl/fma16_arb.sv
// Two-requester round-robin arbiter in front of a shared multi-cycle fp16 FMA datapath.
// One operation in flight; operands held stable for LATENCY cycles, then the result is captured.
module fma16_arb #(
    parameter int unsigned LATENCY = 3
) (
    input logic        clk,
    input logic        reset,
    fma16_arb_if.slave bus
);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic            prio_q;
    logic [CntW-1:0] cnt_q;
    logic [15:0]     x_q;
    logic [15:0]     y_q;
    logic [15:0]     z_q;
    logic            mul_q;
    logic            add_q;
    logic [1:0]      rm_q;
    logic            id_q;
    logic [15:0]     res_q;
    logic [3:0]      flags_q;

    logic            grant;
    logic [1:0]      ready;
    logic [15:0]     sel_x;
    logic [15:0]     sel_y;
    logic [15:0]     sel_z;
    logic            sel_mul;
    logic            sel_add;
    logic [1:0]      sel_rm;

    // Ready is gated by reset so no handshake can be seen on the reset edge.
    always_comb begin
        grant = bus.reqValid[prio_q] ? prio_q : ~prio_q;
        ready = 2'b00;
        if (state_q == StIdle && !reset && bus.reqValid[grant]) begin
            ready[grant] = 1'b1;
        end
        sel_x   = grant ? bus.reqX[31:16] : bus.reqX[15:0];
        sel_y   = grant ? bus.reqY[31:16] : bus.reqY[15:0];
        sel_z   = grant ? bus.reqZ[31:16] : bus.reqZ[15:0];
        sel_mul = bus.reqMul[grant];
        sel_add = bus.reqAdd[grant];
        sel_rm  = grant ? bus.reqRm[3:2] : bus.reqRm[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mul_q   <= 1'b0;
            add_q   <= 1'b0;
            rm_q    <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|ready) begin
                        x_q     <= sel_x;
                        y_q     <= sel_y;
                        z_q     <= sel_z;
                        mul_q   <= sel_mul;
                        add_q   <= sel_add;
                        rm_q    <= sel_rm;
                        id_q    <= grant;
                        prio_q  <= ~grant;
                        cnt_q   <= CntW'(LATENCY);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Capture on the last settling cycle; the counter stops at 1.
                    if (cnt_q == CntW'(1)) begin
                        res_q   <= bus.fmaResult;
                        flags_q <= bus.fmaFlags;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    if (bus.rspReady) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.reqReady  = ready;
    assign bus.fmaX      = x_q;
    assign bus.fmaY      = y_q;
    assign bus.fmaZ      = z_q;
    assign bus.fmaMul    = mul_q;
    assign bus.fmaAdd    = add_q;
    assign bus.fmaRm     = rm_q;
    assign bus.rspValid  = (state_q == StDone);
    assign bus.rspId     = id_q;
    assign bus.rspResult = res_q;
    assign bus.rspFlags  = flags_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_fma16_arb.sv
// Scoreboard bench for fma16_arb: stub datapath that returns garbage until operands have
// settled, a default-latency instance for arbitration/backpressure/reset and a LATENCY=1 instance.
module tb_fma16_arb;
    localparam int unsigned Lat = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fma16_arb_if bus ();
    fma16_arb_if bus1 ();

    fma16_arb #(.LATENCY(Lat)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    fma16_arb #(.LATENCY(1))   u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic [3:0]  flg;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   grant_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stab = 0;
    int   stab1 = 0;
    logic exp_prio = 1'b0;
    logic prev_rv = 1'b0;
    logic [15:0] last_res;

    function automatic logic [15:0] stub_res(logic [15:0] x, logic [15:0] y, logic [15:0] z,
                                             logic m, logic a, logic [1:0] rm);
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && m && a) return 16'h4200;
        return x ^ {y[7:0], y[15:8]} ^ (z + 16'h1234) ^ {m, a, rm, 12'h000};
    endfunction

    function automatic logic [3:0] stub_flg(logic [15:0] x, logic [15:0] y, logic [15:0] z,
                                            logic m, logic a, logic [1:0] rm);
        return x[3:0] ^ y[7:4] ^ z[11:8] ^ {m, a, rm};
    endfunction

    // Stub datapath: correct only once operands have been stable for LATENCY cycles.
    assign bus.fmaResult = (stab >= int'(Lat))
        ? stub_res(bus.fmaX, bus.fmaY, bus.fmaZ, bus.fmaMul, bus.fmaAdd, bus.fmaRm)
        : ~stub_res(bus.fmaX, bus.fmaY, bus.fmaZ, bus.fmaMul, bus.fmaAdd, bus.fmaRm);
    assign bus.fmaFlags = (stab >= int'(Lat))
        ? stub_flg(bus.fmaX, bus.fmaY, bus.fmaZ, bus.fmaMul, bus.fmaAdd, bus.fmaRm)
        : ~stub_flg(bus.fmaX, bus.fmaY, bus.fmaZ, bus.fmaMul, bus.fmaAdd, bus.fmaRm);
    assign bus1.fmaResult = (stab1 >= 1)
        ? stub_res(bus1.fmaX, bus1.fmaY, bus1.fmaZ, bus1.fmaMul, bus1.fmaAdd, bus1.fmaRm)
        : ~stub_res(bus1.fmaX, bus1.fmaY, bus1.fmaZ, bus1.fmaMul, bus1.fmaAdd, bus1.fmaRm);
    assign bus1.fmaFlags = (stab1 >= 1)
        ? stub_flg(bus1.fmaX, bus1.fmaY, bus1.fmaZ, bus1.fmaMul, bus1.fmaAdd, bus1.fmaRm)
        : ~stub_flg(bus1.fmaX, bus1.fmaY, bus1.fmaZ, bus1.fmaMul, bus1.fmaAdd, bus1.fmaRm);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) stab1 = 0;
        else if (|(bus1.reqValid & bus1.reqReady)) stab1 = 0;
        else if (stab1 < 100) stab1++;
    end

    // Monitor: grant model, scoreboard push on accept, latency and response checks.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            exp_prio = 1'b0;
            stab = 0;
            prev_rv = 1'b0;
        end else begin
            check("ready_onehot", 32'(bus.reqReady == 2'b11), 32'd0);
            if (|(bus.reqValid & bus.reqReady)) begin
                logic g;
                logic eg;
                exp_t e;
                g  = bus.reqReady[1];
                eg = bus.reqValid[exp_prio] ? exp_prio : ~exp_prio;
                check("grant", 32'(g), 32'(eg));
                e.id  = g;
                e.res = stub_res(bus.reqX[16*g +: 16], bus.reqY[16*g +: 16], bus.reqZ[16*g +: 16],
                                 bus.reqMul[g], bus.reqAdd[g], bus.reqRm[2*g +: 2]);
                e.flg = stub_flg(bus.reqX[16*g +: 16], bus.reqY[16*g +: 16], bus.reqZ[16*g +: 16],
                                 bus.reqMul[g], bus.reqAdd[g], bus.reqRm[2*g +: 2]);
                e.acc = cyc;
                sbq.push_back(e);
                grant_log.push_back(int'(g));
                exp_prio = ~g;
                stab = 0;
            end else if (stab < 100) begin
                stab++;
            end
            if (bus.rspValid && !prev_rv) begin
                check("rsp_expected", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) check("latency", 32'(cyc), 32'(sbq[0].acc + int'(Lat) + 1));
            end
            prev_rv = bus.rspValid;
            if (bus.rspValid && bus.rspReady && sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_id", 32'(bus.rspId), 32'(e.id));
                check("rsp_result", 32'(bus.rspResult), 32'(e.res));
                check("rsp_flags", 32'(bus.rspFlags), 32'(e.flg));
                last_res = bus.rspResult;
            end
        end
    end

    // Drive one request and hold it until accepted; call at posedge+1.
    task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic m, input logic a,
                         input logic [1:0] rm);
        bit done = 0;
        bus.reqX[16*id +: 16] = x;
        bus.reqY[16*id +: 16] = y;
        bus.reqZ[16*id +: 16] = z;
        bus.reqMul[id] = m;
        bus.reqAdd[id] = a;
        bus.reqRm[2*id +: 2] = rm;
        bus.reqValid[id] = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus.reqReady[id]) done = 1;
        end
        check("req_accepted", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        bus.reqValid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && sbq.size() == 0) ok = 1;
        end
        check("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] eres;
        logic [3:0]  eflg;
        bit          seen;
        int          acc;
        int          rv_count;

        reset = 1'b1;
        bus.reqValid = 2'b11;
        bus.reqX = '0; bus.reqY = '0; bus.reqZ = '0;
        bus.reqMul = '0; bus.reqAdd = '0; bus.reqRm = '0;
        bus.rspReady = 1'b1;
        bus1.reqValid = 2'b00;
        bus1.reqX = '0; bus1.reqY = '0; bus1.reqZ = '0;
        bus1.reqMul = '0; bus1.reqAdd = '0; bus1.reqRm = '0;
        bus1.rspReady = 1'b1;

        // Reset state, with both requests valid during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.reqReady), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rspvalid", 32'(bus.rspValid), 32'd0);
        check("rst_fma_ops", {bus.fmaX, bus.fmaY}, 32'd0);
        check("rst_fma_z_sel", {bus.fmaZ, 10'd0, bus.fmaMul, bus.fmaAdd, bus.fmaRm, 2'b00}, 32'd0);
        check("rst_rsp", {bus.rspResult, 11'd0, bus.rspId, bus.rspFlags}, 32'd0);
        @(posedge clk);
        #1;
        bus.reqValid = 2'b00;
        reset = 1'b0;

        // Single op, then op-select variants including 00.
        issue(0, 16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 2'd0);
        wait_idle();
        check("single_res", 32'(last_res), 32'h4200);
        issue(1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 2'd2);
        wait_idle();
        issue(0, 16'hABCD, 16'h0F0F, 16'h8001, 1'b1, 1'b0, 2'd1);
        wait_idle();
        issue(1, 16'h7BFF, 16'hFC00, 16'h0001, 1'b0, 1'b1, 2'd3);
        wait_idle();

        // Contention from reset: expect grants 0,1,0.
        do_reset();
        grant_log.delete();
        fork
            begin
                issue(0, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b1, 2'd0);
                issue(0, 16'h0102, 16'h0304, 16'h0506, 1'b1, 1'b1, 2'd3);
            end
            issue(1, 16'hCAFE, 16'hBEEF, 16'hF00D, 1'b1, 1'b1, 2'd1);
        join
        wait_idle();
        check("contend_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("contend_g0", 32'(grant_log[0]), 32'd0);
            check("contend_g1", 32'(grant_log[1]), 32'd1);
            check("contend_g2", 32'(grant_log[2]), 32'd0);
        end

        // Requester 1 alone, then both: requester 0 must win next.
        do_reset();
        grant_log.delete();
        issue(1, 16'h4444, 16'h5555, 16'h6666, 1'b1, 1'b1, 2'd2);
        wait_idle();
        fork
            issue(0, 16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b1, 1'b1, 2'd0);
            issue(1, 16'h0DDD, 16'h0EEE, 16'h0FFF, 1'b0, 1'b1, 2'd1);
        join
        wait_idle();
        check("prio_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("prio_g0", 32'(grant_log[0]), 32'd1);
            check("prio_g1", 32'(grant_log[1]), 32'd0);
            check("prio_g2", 32'(grant_log[2]), 32'd1);
        end

        // Backpressure for 10 cycles with requester 1 waiting.
        bus.rspReady = 1'b0;
        eres = stub_res(16'h2468, 16'h1357, 16'h0F1E, 1'b1, 1'b1, 2'd2);
        eflg = stub_flg(16'h2468, 16'h1357, 16'h0F1E, 1'b1, 1'b1, 2'd2);
        issue(0, 16'h2468, 16'h1357, 16'h0F1E, 1'b1, 1'b1, 2'd2);
        fork
            issue(1, 16'h5A5A, 16'hA5A5, 16'h3C3C, 1'b1, 1'b1, 2'd0);
        join_none
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rspValid) seen = 1;
        end
        check("bp_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rspvalid", 32'(bus.rspValid), 32'd1);
            check("bp_result", 32'(bus.rspResult), 32'(eres));
            check("bp_flags", 32'(bus.rspFlags), 32'(eflg));
            check("bp_ready", 32'(bus.reqReady), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_rspvalid", 32'(bus.rspValid), 32'd0);
        check("bp_release_ready", 32'(bus.reqReady), 32'd2);
        wait_idle();

        // Reset in the second BUSY cycle discards the operation.
        issue(0, 16'h1357, 16'h2468, 16'h3579, 1'b1, 1'b1, 2'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_ready", 32'(bus.reqReady), 32'd0);
        check("mid_fma", {bus.fmaX, bus.fmaZ}, 32'd0);
        check("mid_rsp", {bus.rspResult, 10'd0, bus.rspValid, bus.rspId, bus.rspFlags}, 32'd0);
        rv_count = 0;
        for (int i = 0; i < int'(Lat) + 8; i++) begin
            @(negedge clk);
            if (bus.rspValid) rv_count++;
        end
        check("mid_no_rsp", 32'(rv_count), 32'd0);
        @(posedge clk);
        #1;

        // LATENCY=1 instance: accept at t, response at t+2 with settled value.
        bus1.reqX[15:0] = 16'h3800;
        bus1.reqY[15:0] = 16'h4400;
        bus1.reqZ[15:0] = 16'hC000;
        bus1.reqMul[0] = 1'b1;
        bus1.reqAdd[0] = 1'b1;
        bus1.reqRm[1:0] = 2'd1;
        bus1.reqValid = 2'b01;
        seen = 0;
        acc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus1.reqReady[0]) begin
                seen = 1;
                acc = cyc;
            end
        end
        check("l1_accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus1.reqValid = 2'b00;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus1.rspValid) seen = 1;
        end
        check("l1_rsp_seen", 32'(seen), 32'd1);
        check("l1_latency", 32'(cyc - acc), 32'd2);
        check("l1_result", 32'(bus1.rspResult),
              32'(stub_res(16'h3800, 16'h4400, 16'hC000, 1'b1, 1'b1, 2'd1)));
        check("l1_flags", 32'(bus1.rspFlags),
              32'(stub_flg(16'h3800, 16'h4400, 16'hC000, 1'b1, 1'b1, 2'd1)));
        check("l1_id", 32'(bus1.rspId), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l1_idle", 32'(bus1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fma16_arb.md
FMA16_ARB -- requirements
Module: fma16_arb

Interface
REQ-001 Parameter: LATENCY, default 3, number of cycles the shared fp16 FMA datapath needs for operands to settle; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: reqValid  input  2  per-requester operation valid, bit i = requester i.
REQ-005 Port: reqReady  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 Port: reqX, reqY, reqZ  input  32 each  packed fp16 operands, bits [16i+15:16i] belong to requester i.
REQ-007 Port: reqMul, reqAdd  input  2 each  per-requester op select: 11 = fma, 10 = mul only, 01 = add only.
REQ-008 Port: reqRm  input  4  packed 2-bit rounding mode per requester.
REQ-009 Port: fmaX, fmaY, fmaZ  output  16 each  registered operands driven to the shared datapath.
REQ-010 Port: fmaMul, fmaAdd  output  1 each  registered op select to datapath.
REQ-011 Port: fmaRm  output  2  registered rounding mode to datapath.
REQ-012 Port: fmaResult  input  16  datapath result; valid only after LATENCY stable cycles.
REQ-013 Port: fmaFlags  input  4  datapath exception flags {invalid, overflow, underflow, inexact}.
REQ-014 Port: rspValid  output  1  response available.
REQ-015 Port: rspReady  input  1  consumer accepts response.
REQ-016 Port: rspId  output  1  index of requester owning the response.
REQ-017 Port: rspResult  output  16  captured result.
REQ-018 Port: rspFlags  output  4  captured flags.
REQ-019 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, BUSY, DONE; one operation in flight at a time.
REQ-021 IDLE: grant = prio if reqValid[prio], else ~prio if reqValid[~prio]; reqReady[grant] = 1 combinationally; reqReady = 00 in BUSY/DONE or with no valid request.
REQ-022 Handshake reqValid[g] & reqReady[g] in IDLE: latch requester g's operands, mul, add, rm into fma* registers and g into rspId; load countdown cnt = LATENCY; prio <= ~g; next state BUSY.
REQ-023 Requester not granted is unaffected and retains its request; requester may not withdraw valid before ready (bench checks, RTL does not).
REQ-024 BUSY: fma* outputs held stable; cnt decrements each cycle; when cnt == 1, capture fmaResult, fmaFlags into rspResult, rspFlags, next state DONE.
REQ-025 Latency: request accepted at edge t produces rspValid = 1 from cycle t+LATENCY+1 onward.
REQ-026 DONE: rspValid = 1, rsp* stable; on rspReady next state IDLE; without rspReady remain in DONE indefinitely (backpressure).
REQ-027 No new request accepted in the DONE cycle where rspReady is taken; minimum request-to-request spacing is LATENCY+2 cycles.
REQ-028 Op select 00 is accepted and sequenced identically; datapath output passed through unchanged.
REQ-029 Counter width $clog2(LATENCY+1); no wrap: cnt never decrements below 1 in BUSY.
REQ-030 Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1...

Reset
REQ-031 reset = 1 at rising edge: state IDLE, prio = 0, cnt = 0, fma* = 0, rspId = 0, rspResult = 0, rspFlags = 0, rspValid = 0, reqReady = 00, busy = 0.
REQ-032 Reset in BUSY or DONE discards the in-flight operation; no response is ever presented for it.

Verification
REQ-033 Single op: after reset, reqValid = 01, x = 3C00, y = 4000, z = 3C00, mul = add = 1, stub datapath returns 4200 -> reqReady[0] at cycle t, rspValid at t+4, rspId = 0, rspResult = 4200.
REQ-034 Contention: reqValid = 11 held -> grants to 0 then 1 then 0; rspId sequence 0,1,0; reqReady never 11.
REQ-035 Backpressure: rspReady = 0 for 10 cycles after rspValid -> rspValid, rspResult, rspFlags stable, reqReady = 00, busy = 1 throughout; release -> IDLE next cycle.
REQ-036 Reset mid-op: reset asserted in second BUSY cycle -> next cycle all outputs zero, state IDLE, no rspValid afterwards.
REQ-037 LATENCY = 1 build: accept at t -> rspValid at t+2; stub changes fmaResult before capture cycle only.
REQ-038 Priority after single requester: requester 1 alone granted, then reqValid = 11 -> requester 0 granted next.
